// File: rtl/dmem_pipe_pkg.sv
// Shared types and sizing helpers for the pipelined data memory.
package dmem_pipe_pkg;

    localparam int unsigned DATA_W_32   = 32;
    localparam int unsigned DATA_W_64   = 64;
    localparam int unsigned PIPE_DATA_W = DATA_W_64;
    localparam int unsigned PIPE_TAG_W  = 4;

    // Pointer width for an n-entry structure; never zero.
    function automatic int unsigned idx_w(int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a counter that must hold the value n itself.
    function automatic int unsigned cnt_w(int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned mem_depth(int unsigned kb, int unsigned dw);
        return kb * 1024 * 8 / dw;
    endfunction

    function automatic bit data_w_legal(int unsigned w);
        return (w == DATA_W_32) || (w == DATA_W_64);
    endfunction

    typedef struct packed {
        logic                   valid;
        logic [PIPE_TAG_W-1:0]  tag;
        logic [PIPE_DATA_W-1:0] data;
        logic                   err;
    } ld_pipe_t;

endpackage

// File: rtl/dmem_pipe_if.sv
// LSU <-> data memory bus: load request/response and store request/completion channels.
interface dmem_pipe_if #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LDTAG_W = 4
);
    logic                  ld_valid;
    logic                  ld_ready;
    logic [ADDR_W-1:0]     ld_addr;
    logic [LDTAG_W-1:0]    ld_tag;
    logic                  ld_resp_valid;
    logic                  ld_resp_ready;
    logic [DATA_W-1:0]     ld_resp_data;
    logic [LDTAG_W-1:0]    ld_resp_tag;
    logic                  ld_resp_err;
    logic                  st_valid;
    logic                  st_ready;
    logic [ADDR_W-1:0]     st_addr;
    logic [DATA_W-1:0]     st_wdata;
    logic [DATA_W/8-1:0]   st_wstrb;
    logic                  st_resp_valid;
    logic                  st_resp_ready;

    modport master (
        output ld_valid, ld_addr, ld_tag, ld_resp_ready,
        output st_valid, st_addr, st_wdata, st_wstrb, st_resp_ready,
        input  ld_ready, ld_resp_valid, ld_resp_data, ld_resp_tag, ld_resp_err,
        input  st_ready, st_resp_valid
    );

    modport slave (
        input  ld_valid, ld_addr, ld_tag, ld_resp_ready,
        input  st_valid, st_addr, st_wdata, st_wstrb, st_resp_ready,
        output ld_ready, ld_resp_valid, ld_resp_data, ld_resp_tag, ld_resp_err,
        output st_ready, st_resp_valid
    );
endinterface

// File: rtl/dmem_resp_fifo.sv
// Synchronous FIFO for load responses; push while full is legal only together with a pop.
module dmem_resp_fifo import dmem_pipe_pkg::*; #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int unsigned PW = idx_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/dmem_pipe.sv
// Fully pipelined data memory: one load and one store per cycle, credit-limited response FIFO.
// Optional DMEM_BOUNDS_CHECK_EN flags loads beyond MEM_SIZE_KB and suppresses such stores.
module dmem_pipe import dmem_pipe_pkg::*; #(
    parameter int unsigned MEM_SIZE_KB = 64,
    parameter int unsigned DATA_W      = PIPE_DATA_W,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LDTAG_W     = PIPE_TAG_W,
    parameter int unsigned LD_LATENCY  = 2,
    parameter int unsigned ST_LATENCY  = 2,
    parameter int unsigned RESP_DEPTH  = 4,
    parameter int unsigned ST_DEPTH    = 4
) (
    input logic        clk,
    input logic        rst,
    dmem_pipe_if.slave bus
);
    localparam int unsigned BYTES    = DATA_W / 8;
    localparam int unsigned OFF_W    = $clog2(BYTES);
    localparam int unsigned DEPTH    = mem_depth(MEM_SIZE_KB, DATA_W);
    localparam int unsigned IDX_W    = idx_w(DEPTH);
    localparam int unsigned IDX_HI   = IDX_W + OFF_W - 1;
    localparam int unsigned CRED_W   = cnt_w(RESP_DEPTH);
    localparam int unsigned ST_CW    = cnt_w(ST_DEPTH);
    localparam int unsigned ENT_W    = 1 + LDTAG_W + DATA_W;
    localparam int unsigned FIFO_CW  = cnt_w(RESP_DEPTH);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               ld_accept, st_accept, ld_pop, st_ack;
    logic [IDX_W-1:0]   ld_idx, st_idx;
    logic               ld_oob, st_oob;
    logic [DATA_W-1:0]  rd_word;
    ld_pipe_t           pipe_q [LD_LATENCY];
    logic [CRED_W-1:0]  cred_q;
    logic [ENT_W-1:0]   fifo_head;
    logic               fifo_empty;
    logic               head_err;
    logic [LDTAG_W-1:0] head_tag;
    logic [DATA_W-1:0]  head_data;
    logic [ST_LATENCY-1:0] st_dly_q;
    logic [ST_CW-1:0]   st_pend_q, st_done_q;
    logic               unused_full;
    logic [FIFO_CW-1:0] unused_count;
    logic               unused_addr_bits;

    assign ld_idx = bus.ld_addr[IDX_HI:OFF_W];
    assign st_idx = bus.st_addr[IDX_HI:OFF_W];
    assign unused_addr_bits = ^{bus.ld_addr[OFF_W-1:0], bus.ld_addr[ADDR_W-1:IDX_HI+1],
                                bus.st_addr[OFF_W-1:0], bus.st_addr[ADDR_W-1:IDX_HI+1]};

`ifdef DMEM_BOUNDS_CHECK_EN
    assign ld_oob = 64'(bus.ld_addr) >= 64'(MEM_SIZE_KB) * 64'd1024;
    assign st_oob = 64'(bus.st_addr) >= 64'(MEM_SIZE_KB) * 64'd1024;
`else
    assign ld_oob = 1'b0;
    assign st_oob = 1'b0;
`endif

    // Nothing is accepted during reset so no write lands in the reset cycle.
    assign ld_accept = bus.ld_valid & bus.ld_ready & ~rst;
    assign st_accept = bus.st_valid & bus.st_ready & ~rst;
    assign ld_pop    = bus.ld_resp_valid & bus.ld_resp_ready;
    assign st_ack    = bus.st_resp_valid & bus.st_resp_ready;

    // Write-first merge so a same-cycle store to the same word is visible to the load.
    always_comb begin
        rd_word = mem_q[ld_idx];
        if (st_accept && !st_oob && (st_idx == ld_idx)) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.st_wstrb[b]) rd_word[b*8 +: 8] = bus.st_wdata[b*8 +: 8];
            end
        end
        if (ld_oob) rd_word = '0;
    end

    always_ff @(posedge clk) begin
        if (st_accept && !st_oob) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.st_wstrb[b]) mem_q[st_idx][b*8 +: 8] <= bus.st_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LD_LATENCY; i++) pipe_q[i] <= '0;
            cred_q <= '0;
        end else begin
            pipe_q[0] <= '{valid: ld_accept, tag: bus.ld_tag, data: rd_word, err: ld_oob};
            for (int i = 1; i < LD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
            cred_q <= cred_q + CRED_W'(ld_accept) - CRED_W'(ld_pop);
        end
    end

    // Credits cover pipeline plus FIFO, so the FIFO can never overflow.
    assign bus.ld_ready = (cred_q < CRED_W'(RESP_DEPTH));

    dmem_resp_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pipe_q[LD_LATENCY-1].valid),
        .push_data ({pipe_q[LD_LATENCY-1].err, pipe_q[LD_LATENCY-1].tag,
                     pipe_q[LD_LATENCY-1].data}),
        .pop       (ld_pop),
        .head      (fifo_head),
        .full      (unused_full),
        .empty     (fifo_empty),
        .count     (unused_count)
    );

    assign {head_err, head_tag, head_data} = fifo_head;
    assign bus.ld_resp_valid = ~fifo_empty;
    assign bus.ld_resp_data  = fifo_empty ? '0 : head_data;
    assign bus.ld_resp_tag   = fifo_empty ? '0 : head_tag;
    assign bus.ld_resp_err   = ~fifo_empty & head_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_dly_q  <= '0;
            st_pend_q <= '0;
            st_done_q <= '0;
        end else begin
            st_dly_q  <= (st_dly_q << 1) | ST_LATENCY'(st_accept);
            st_done_q <= st_done_q + ST_CW'(st_dly_q[ST_LATENCY-1]) - ST_CW'(st_ack);
            st_pend_q <= st_pend_q + ST_CW'(st_accept) - ST_CW'(st_ack);
        end
    end

    assign bus.st_ready      = (st_pend_q < ST_CW'(ST_DEPTH));
    assign bus.st_resp_valid = (st_done_q != '0);
endmodule

// File: tb/tb_dmem_pipe.sv
// Scoreboard bench for dmem_pipe: directed loads/stores, monitor pops expected responses.
module tb_dmem_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    dmem_pipe_if #(.DATA_W(64), .ADDR_W(32), .LDTAG_W(4)) bus ();

    dmem_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        logic        err;
    } ld_exp_t;

    ld_exp_t ld_q[$];
    ld_exp_t mon_e;
    int      st_exp  = 0;
    int      n_checks = 0;
    int      n_pass   = 0;

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.ld_resp_valid && bus.ld_resp_ready) begin
                if (ld_q.size() == 0) begin
                    check("ld_resp_unexpected", 64'(bus.ld_resp_valid), 64'd0);
                end else begin
                    mon_e = ld_q.pop_front();
                    check("ld_resp_tag",  64'(bus.ld_resp_tag), 64'(mon_e.tag));
                    check("ld_resp_data", bus.ld_resp_data,     mon_e.data);
                    check("ld_resp_err",  64'(bus.ld_resp_err), 64'(mon_e.err));
                end
            end
            if (bus.st_resp_valid && bus.st_resp_ready) begin
                if (st_exp == 0) check("st_resp_unexpected", 64'(bus.st_resp_valid), 64'd0);
                else st_exp--;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
    end

    task automatic ld_idle();
        bus.ld_valid = 1'b0;
    endtask

    task automatic st_idle();
        bus.st_valid = 1'b0;
        bus.st_wstrb = '0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept with valid still high.
    task automatic ld_issue(input logic [31:0] addr, input logic [3:0] tag,
                            input logic [63:0] data, input logic err, input bit expect_resp);
        ld_exp_t e;
        int n = 0;
        bus.ld_valid = 1'b1;
        bus.ld_addr  = addr;
        bus.ld_tag   = tag;
        @(negedge clk);
        while (!bus.ld_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("ld_accept_timeout", 64'(bus.ld_ready), 64'd1);
        else if (expect_resp) begin
            e.tag = tag; e.data = data; e.err = err;
            ld_q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic st_issue(input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] strb);
        int n = 0;
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_wdata = data;
        bus.st_wstrb = strb;
        @(negedge clk);
        while (!bus.st_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("st_accept_timeout", 64'(bus.st_ready), 64'd1);
        else st_exp++;
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((ld_q.size() != 0 || st_exp != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(ld_q.size() + st_exp), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ld_resp_valid"}, 64'(bus.ld_resp_valid), 64'd0);
        check({tag, "_st_resp_valid"}, 64'(bus.st_resp_valid), 64'd0);
        check({tag, "_ld_resp_data"},  bus.ld_resp_data,       64'd0);
        check({tag, "_ld_resp_tag"},   64'(bus.ld_resp_tag),   64'd0);
        check({tag, "_ld_resp_err"},   64'(bus.ld_resp_err),   64'd0);
        check({tag, "_ld_ready"},      64'(bus.ld_ready),      64'd1);
        check({tag, "_st_ready"},      64'(bus.st_ready),      64'd1);
    endtask

    initial begin
        int n;
        ld_exp_t e;
        bus.ld_valid = 0; bus.ld_addr = '0; bus.ld_tag = '0; bus.ld_resp_ready = 1'b1;
        bus.st_valid = 0; bus.st_addr = '0; bus.st_wdata = '0; bus.st_wstrb = '0;
        bus.st_resp_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Store then load back, measuring load latency.
        st_issue(32'h40, 64'h1122334455667788, 8'hFF);
        st_idle();
        wait_drain("drain_store1");
        ld_issue(32'h40, 4'd3, 64'h1122334455667788, 1'b0, 1'b1);
        ld_idle();
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (bus.ld_resp_valid) break;
            n++;
        end
        check("ld_latency", 64'(n), 64'd2);
        @(posedge clk); #1;
        wait_drain("drain_load1");

        // Four loads under backpressure fill the credits.
        bus.ld_resp_ready = 1'b0;
        for (int t = 0; t < 4; t++) ld_issue(32'h40, 4'(t), 64'h1122334455667788, 1'b0, 1'b1);
        ld_idle();
        @(negedge clk);
        check("ld_ready_full", 64'(bus.ld_ready), 64'd0);
        repeat (4) @(negedge clk);
        check("ld_head_valid_stall", 64'(bus.ld_resp_valid), 64'd1);
        check("ld_head_tag_stall",   64'(bus.ld_resp_tag),   64'd0);
        @(negedge clk);
        check("ld_head_tag_stable",  64'(bus.ld_resp_tag),   64'd0);
        @(posedge clk); #1;
        bus.ld_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ld_resp_consecutive", 64'(bus.ld_resp_valid), 64'd1);
        end
        @(negedge clk);
        check("ld_ready_returns", 64'(bus.ld_ready), 64'd1);
        check("ld_fifo_empty",    64'(bus.ld_resp_valid), 64'd0);
        @(posedge clk); #1;

        // Same-cycle partial store and load to one word.
        st_issue(32'h80, 64'h0, 8'hFF);
        st_idle();
        wait_drain("drain_zero80");
        bus.st_valid = 1'b1; bus.st_addr = 32'h80;
        bus.st_wdata = 64'hAAAAAAAAAAAAAAAA; bus.st_wstrb = 8'h0F;
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h80; bus.ld_tag = 4'd9;
        @(negedge clk);
        check("same_cycle_ld_ready", 64'(bus.ld_ready), 64'd1);
        check("same_cycle_st_ready", 64'(bus.st_ready), 64'd1);
        e.tag = 4'd9; e.data = 64'h00000000AAAAAAAA; e.err = 1'b0;
        ld_q.push_back(e);
        st_exp++;
        @(posedge clk); #1;
        st_idle(); ld_idle();
        ld_issue(32'h84, 4'd10, 64'h00000000AAAAAAAA, 1'b0, 1'b1);
        ld_idle();
        // Zero-strobe store still completes and leaves memory untouched.
        st_issue(32'h40, 64'hDEADBEEFDEADBEEF, 8'h00);
        st_idle();
        ld_issue(32'h40, 4'd11, 64'h1122334455667788, 1'b0, 1'b1);
        ld_idle();
        wait_drain("drain_merge");

        // Store credits: four pending, fifth refused.
        bus.st_resp_ready = 1'b0;
        for (int s = 0; s < 4; s++) st_issue(32'hC0 + 32'(s * 8), 64'(s), 8'hFF);
        bus.st_addr = 32'hE0; bus.st_wdata = 64'h5; bus.st_wstrb = 8'hFF;
        @(negedge clk);
        check("st_ready_full", 64'(bus.st_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("st_ready_still_full", 64'(bus.st_ready), 64'd0);
        check("st_resp_pending",     64'(bus.st_resp_valid), 64'd1);
        @(posedge clk); #1;
        st_idle();
        bus.st_resp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus.st_resp_ready = 1'b0;
        @(negedge clk);
        check("st_acks_done",    64'(st_exp), 64'd0);
        check("st_ready_return", 64'(bus.st_ready), 64'd1);
        check("st_resp_clear",   64'(bus.st_resp_valid), 64'd0);
        @(posedge clk); #1;
        bus.st_resp_ready = 1'b1;

        // Reset with two loads in flight drops them.
        ld_issue(32'h40, 4'd5, 64'h0, 1'b0, 1'b0);
        ld_issue(32'h40, 4'd6, 64'h0, 1'b0, 1'b0);
        ld_idle();
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.ld_resp_valid) n++;
        end
        check("rst_drops_loads", 64'(n), 64'd0);
        @(posedge clk); #1;

        // Address one past the end of memory.
        st_issue(32'h0, 64'hCAFEF00D12345678, 8'hFF);
        st_idle();
        wait_drain("drain_store0");
`ifdef DMEM_BOUNDS_CHECK_EN
        ld_issue(32'h10000, 4'd7, 64'h0, 1'b1, 1'b1);
`else
        ld_issue(32'h10000, 4'd7, 64'hCAFEF00D12345678, 1'b0, 1'b1);
`endif
        ld_idle();
        wait_drain("drain_final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dmem_pipe.md
Name: dmem_pipe

Overview:
- Parametrised successor of the fixed-latency stall-based data memory model.
- Accepts one load and one store per cycle, fully pipelined: multiple loads in flight, tagged in-order responses buffered in a response FIFO with backpressure, and multiple outstanding store completions.
- Sits between the LSU and an inferred single-clock, byte-writable memory array; no vendor IP.

Parameters:
- MEM_SIZE_KB, 64, memory capacity in KiB.
- DATA_W, 64, data word width in bits; 32 or 64 only.
- ADDR_W, 32, byte address width.
- LDTAG_W, 4, load tag width.
- LD_LATENCY, 2, cycles from load accept to data entering the response FIFO; range 1..8.
- ST_LATENCY, 2, cycles from store accept to completion being eligible; range 1..8.
- RESP_DEPTH, 4, load response FIFO depth; power of two, at least 2.
- ST_DEPTH, 4, maximum stores accepted but not yet acknowledged.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ld_valid  in  1  load request valid.
- ld_ready  out  1  load request accepted when high together with ld_valid.
- ld_addr  in  ADDR_W  load byte address; low log2(DATA_W/8) bits ignored.
- ld_tag  in  LDTAG_W  load tag.
- ld_resp_valid  out  1  load response valid.
- ld_resp_ready  in  1  LSU accepts the load response.
- ld_resp_data  out  DATA_W  full aligned word.
- ld_resp_tag  out  LDTAG_W  echoed load tag.
- ld_resp_err  out  1  load error flag.
- st_valid  in  1  store request valid.
- st_ready  out  1  store request accepted when high together with st_valid.
- st_addr  in  ADDR_W  store byte address; low bits ignored.
- st_wdata  in  DATA_W  store data.
- st_wstrb  in  DATA_W/8  byte write strobes.
- st_resp_valid  out  1  store completion valid.
- st_resp_ready  in  1  LSU accepts the store completion.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: ld_resp_valid=0, st_resp_valid=0, ld_resp_data=0, ld_resp_tag=0, ld_resp_err=0, ld_ready=1, st_ready=1.
  - All pipeline valid bits, FIFO pointers and counters are cleared.
  - Memory contents are not cleared.
  - A reset asserted mid-operation drops all in-flight loads and stores. Array writes already performed are kept.
- Word index: addr[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)], where DEPTH = MEM_SIZE_KB*1024*8/DATA_W.
- Load path:
  - A load is accepted on ld_valid & ld_ready.
  - The array read happens in the accept cycle. Data and tag then move down a valid-tagged shift pipeline of LD_LATENCY stages and are pushed into the response FIFO.
  - Sustained throughput is one load per cycle.
- Load credits:
  - credits_used = loads in the pipeline + FIFO occupancy.
  - ld_ready = (credits_used < RESP_DEPTH). This is registered-safe: it uses only the current cycle's count and never a combinational path from ld_valid.
  - The FIFO therefore never overflows, and the pipeline never stalls.
- Load responses:
  - Returned in acceptance order.
  - The FIFO head drives ld_resp_*.
  - The head is popped on ld_resp_valid & ld_resp_ready.
  - A push and a pop in the same cycle are legal at any occupancy, including full.
  - ld_resp_* stay stable while valid and not ready.
- Store path:
  - A store is accepted on st_valid & st_ready.
  - The array is written in the accept cycle, per byte where st_wstrb is set.
  - A delay line of ST_LATENCY stages carries one valid bit per store.
  - Each exiting bit increments a done counter.
  - st_resp_valid = (done counter != 0). Each st_resp_valid & st_resp_ready decrements it.
  - pending = accepted and not yet acknowledged; st_ready = (pending < ST_DEPTH).
  - An increment and a decrement in the same cycle leave the count unchanged.
- Same-cycle load and store to the same word: the load returns the merged data (write-first, byte-wise by st_wstrb).
- Ordering: a load accepted after a store observes that store.
- st_wstrb = 0: no write, but a completion is still generated.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - A load whose address is at or above MEM_SIZE_KB*1024 returns ld_resp_err=1 and ld_resp_data=0.
  - An out-of-range store performs no write but still completes normally.
- Undefined:
  - Addresses wrap modulo the memory size.
  - ld_resp_err is tied to 0.

Decomposition:
- Package dmem_pipe_pkg:
  - function clog2-based localparam helpers.
  - typedef ld_pipe_t (valid, tag, data, err), parametrised through DATA_W/LDTAG_W localparams.
  - constants for legal DATA_W values.
- One sub-module, dmem_resp_fifo: a synchronous FIFO (push, pop, full, empty, count) parametrised on width and depth, used for load responses.

Test Plan:
- Store 0x1122334455667788 to 0x40 with wstrb 0xFF, wait for st_resp, then load 0x40 tag 3 -> after LD_LATENCY cycles the response is tag 3, data 0x1122334455667788, err 0.
- Four back-to-back loads, tags 0..3, with ld_resp_ready=0 -> ld_ready falls after the 4th accept; set ready=1 -> responses come out in tags 0,1,2,3 order on consecutive cycles, and ld_ready returns.
- In the same cycle, store 0xAAAA...AA wstrb 0x0F to 0x80 and load 0x80 (old 0) -> response data 0x00000000AAAAAAAA.
- Five stores with st_resp_ready=0 -> st_ready=0 after the 4th; 4 completions pending; then pulse ready 4 cycles -> 4 acks and st_ready=1.
- Assert rst with 2 loads in flight -> no ld_resp_valid afterwards; all outputs at their reset values next cycle.
- With DMEM_BOUNDS_CHECK_EN, load 0x10000 -> err=1, data 0. Without it, the same load returns the word stored at 0x0.
